// File: rtl/trdb_packet_parser.sv
// trdb_packet_parser: receive side of the trace packet path. Collects a
// length-prefixed byte stream into a payload buffer, then decodes the
// format/subformat and fields into registered outputs held until accepted.
module trdb_packet_parser #(
    parameter int XLEN      = 32,
    parameter int PRIV_W    = 2,
    parameter int CAUSE_W   = 5,
    parameter int MAX_BYTES = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [7:0]         byte_i,
    input  logic               byte_valid_i,
    output logic               byte_ready_o,
    output logic               packet_valid_o,
    input  logic               packet_ready_i,
    output logic [1:0]         format_o,
    output logic [1:0]         subformat_o,
    output logic               branch_o,
    output logic [PRIV_W-1:0]  priv_o,
    output logic [XLEN-1:0]    iaddr_o,
    output logic [CAUSE_W-1:0] ecause_o,
    output logic               interrupt_o,
    output logic               thaddr_o,
    output logic [XLEN-1:0]    tval_o,
    output logic               ienable_o,
    output logic               encoder_mode_o,
    output logic [1:0]         qual_status_o,
    output logic [2:0]         ioptions_o,
    output logic [4:0]         branches_o,
    output logic [31:0]        branch_map_o,
    output logic               notify_o,
    output logic               updiscon_o,
    output logic               irreport_o,
    output logic               err_o,
    output logic [1:0]         err_code_o
);

    // Bit offsets of the variable-position fields inside the payload.
    localparam int BUF_W     = MAX_BYTES * 8;
    localparam int SF0_ADDR  = 5 + PRIV_W;
    localparam int SF1_CAUSE = 5 + PRIV_W;
    localparam int SF1_INTR  = SF1_CAUSE + CAUSE_W;
    localparam int SF1_ADDR  = SF1_INTR + 2;
    localparam int SF1_TVAL  = SF1_ADDR + XLEN;
    localparam int F2_FLAGS  = 2 + XLEN;
    localparam int F1_ADDR   = 39;
    localparam int F1_FLAGS  = F1_ADDR + XLEN;

    // Required payload lengths: ceil(total field bits / 8).
    localparam logic [7:0] LEN_SF0      = 8'((SF0_ADDR + XLEN + 7) / 8);
    localparam logic [7:0] LEN_SF1      = 8'((SF1_TVAL + XLEN + 7) / 8);
    localparam logic [7:0] LEN_SF2      = 8'((4 + PRIV_W + 7) / 8);
    localparam logic [7:0] LEN_SF3      = 8'((11 + 7) / 8);
    localparam logic [7:0] LEN_F2       = 8'((F2_FLAGS + 3 + 7) / 8);
    localparam logic [7:0] LEN_F1_SHORT = 8'((F1_ADDR + 7) / 8);
    localparam logic [7:0] LEN_F1_FULL  = 8'((F1_FLAGS + 3 + 7) / 8);

    typedef enum logic [1:0] {IDLE, COLLECT, DECODE, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [7:0]       len_reg, cnt_reg;
    logic [7:0]       buf_mem [MAX_BYTES];
    logic [BUF_W-1:0] buf_flat;
    logic             ready_state, xfer, last_byte;
    logic             buf_unused;

    // Decoded values presented to the output registers in DECODE.
    logic [1:0]         dec_format, dec_subformat, dec_err_code, dec_qual;
    logic [7:0]         req_len;
    logic               dec_branch, dec_intr, dec_thaddr, dec_ien, dec_enc;
    logic               dec_notify, dec_updiscon, dec_irreport;
    logic [PRIV_W-1:0]  dec_priv;
    logic [XLEN-1:0]    dec_iaddr, dec_tval;
    logic [CAUSE_W-1:0] dec_ecause;
    logic [2:0]         dec_iopt;
    logic [4:0]         dec_branches;
    logic [31:0]        dec_bmap;

    generate
        for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_flat
            assign buf_flat[gi*8 +: 8] = buf_mem[gi];
        end
    endgenerate

    // Trailing buffer bits beyond the widest format are intentionally unread.
    assign buf_unused   = ^buf_flat;
    assign byte_ready_o = ready_state & ~rst_i;
    assign xfer         = byte_valid_i & byte_ready_o;
    assign last_byte    = (cnt_reg == len_reg - 8'd1);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic and stream back-pressure.
    always_comb begin
        state_next  = state_reg;
        ready_state = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_state = 1'b1;
                if (xfer && byte_i != 8'd0) state_next = COLLECT;
            end
            COLLECT: begin
                ready_state = 1'b1;
                if (xfer && last_byte) state_next = DECODE;
            end
            DECODE:  state_next = HOLD;
            HOLD:    if (packet_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Length latch, byte counter and payload buffer; bytes past the buffer are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_reg <= 8'd0;
            cnt_reg <= 8'd0;
            for (int i = 0; i < MAX_BYTES; i++) buf_mem[i] <= 8'd0;
        end else if (state_reg == IDLE && xfer && byte_i != 8'd0) begin
            len_reg <= byte_i;
            cnt_reg <= 8'd0;
            for (int i = 0; i < MAX_BYTES; i++) buf_mem[i] <= 8'd0;
        end else if (state_reg == COLLECT && xfer) begin
            cnt_reg <= cnt_reg + 8'd1;
            for (int i = 0; i < MAX_BYTES; i++)
                if (cnt_reg == 8'(i)) buf_mem[i] <= byte_i;
        end
    end

    // Field extraction and error classification from the collected payload.
    always_comb begin
        dec_format    = buf_flat[1:0];
        dec_subformat = (buf_flat[1:0] == 2'd3) ? buf_flat[3:2] : 2'd0;
        dec_err_code  = 2'd0;
        req_len       = 8'd0;
        dec_branch    = 1'b0;
        dec_priv      = '0;
        dec_iaddr     = '0;
        dec_ecause    = '0;
        dec_intr      = 1'b0;
        dec_thaddr    = 1'b0;
        dec_tval      = '0;
        dec_ien       = 1'b0;
        dec_enc       = 1'b0;
        dec_qual      = 2'd0;
        dec_iopt      = 3'd0;
        dec_branches  = 5'd0;
        dec_bmap      = 32'd0;
        dec_notify    = 1'b0;
        dec_updiscon  = 1'b0;
        dec_irreport  = 1'b0;

        case (dec_format)
            2'd3: case (dec_subformat)
                2'd0:    req_len = LEN_SF0;
                2'd1:    req_len = LEN_SF1;
                2'd2:    req_len = LEN_SF2;
                default: req_len = LEN_SF3;
            endcase
            2'd2:    req_len = LEN_F2;
            2'd1:    req_len = (buf_flat[6:2] == 5'h1f) ? LEN_F1_SHORT : LEN_F1_FULL;
            default: req_len = 8'd0;
        endcase

        if (len_reg > 8'(MAX_BYTES))  dec_err_code = 2'd3;
        else if (dec_format == 2'd0)  dec_err_code = 2'd2;
        else if (len_reg != req_len)  dec_err_code = 2'd1;

        if (dec_err_code == 2'd0) begin
            case (dec_format)
                2'd3: case (dec_subformat)
                    2'd0: begin
                        dec_branch = buf_flat[4];
                        dec_priv   = buf_flat[5 +: PRIV_W];
                        dec_iaddr  = buf_flat[SF0_ADDR +: XLEN];
                    end
                    2'd1: begin
                        dec_branch = buf_flat[4];
                        dec_priv   = buf_flat[5 +: PRIV_W];
                        dec_ecause = buf_flat[SF1_CAUSE +: CAUSE_W];
                        dec_intr   = buf_flat[SF1_INTR];
                        dec_thaddr = buf_flat[SF1_INTR + 1];
                        dec_iaddr  = buf_flat[SF1_ADDR +: XLEN];
                        dec_tval   = buf_flat[SF1_TVAL +: XLEN];
                    end
                    2'd2: dec_priv = buf_flat[4 +: PRIV_W];
                    default: begin
                        dec_ien  = buf_flat[4];
                        dec_enc  = buf_flat[5];
                        dec_qual = buf_flat[7:6];
                        dec_iopt = buf_flat[10:8];
                    end
                endcase
                2'd2: begin
                    dec_iaddr    = buf_flat[2 +: XLEN];
                    dec_notify   = buf_flat[F2_FLAGS];
                    dec_updiscon = buf_flat[F2_FLAGS + 1];
                    dec_irreport = buf_flat[F2_FLAGS + 2];
                end
                default: begin
                    dec_branches = buf_flat[6:2];
                    dec_bmap     = buf_flat[38:7];
                    if (buf_flat[6:2] != 5'h1f) begin
                        dec_iaddr    = buf_flat[F1_ADDR +: XLEN];
                        dec_notify   = buf_flat[F1_FLAGS];
                        dec_updiscon = buf_flat[F1_FLAGS + 1];
                        dec_irreport = buf_flat[F1_FLAGS + 2];
                    end
                end
            endcase
        end
    end

    // Output registers: loaded in DECODE, held through HOLD until handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            packet_valid_o <= 1'b0;
            format_o       <= 2'd0;
            subformat_o    <= 2'd0;
            branch_o       <= 1'b0;
            priv_o         <= '0;
            iaddr_o        <= '0;
            ecause_o       <= '0;
            interrupt_o    <= 1'b0;
            thaddr_o       <= 1'b0;
            tval_o         <= '0;
            ienable_o      <= 1'b0;
            encoder_mode_o <= 1'b0;
            qual_status_o  <= 2'd0;
            ioptions_o     <= 3'd0;
            branches_o     <= 5'd0;
            branch_map_o   <= 32'd0;
            notify_o       <= 1'b0;
            updiscon_o     <= 1'b0;
            irreport_o     <= 1'b0;
            err_o          <= 1'b0;
            err_code_o     <= 2'd0;
        end else if (state_reg == DECODE) begin
            packet_valid_o <= 1'b1;
            format_o       <= dec_format;
            subformat_o    <= dec_subformat;
            branch_o       <= dec_branch;
            priv_o         <= dec_priv;
            iaddr_o        <= dec_iaddr;
            ecause_o       <= dec_ecause;
            interrupt_o    <= dec_intr;
            thaddr_o       <= dec_thaddr;
            tval_o         <= dec_tval;
            ienable_o      <= dec_ien;
            encoder_mode_o <= dec_enc;
            qual_status_o  <= dec_qual;
            ioptions_o     <= dec_iopt;
            branches_o     <= dec_branches;
            branch_map_o   <= dec_bmap;
            notify_o       <= dec_notify;
            updiscon_o     <= dec_updiscon;
            irreport_o     <= dec_irreport;
            err_o          <= (dec_err_code != 2'd0);
            err_code_o     <= dec_err_code;
        end else if (state_reg == HOLD && packet_ready_i) begin
            packet_valid_o <= 1'b0;
        end
    end

endmodule
